// File: rtl/nfu3_seq_ctrl.sv
// NFU-3 sigmoid-stage sequencer: loads the per-lane {ai,bi} coefficient table,
// then gates the NFU-2 operand stream and tracks results through the sigmoid pipe.
module nfu3_seq_ctrl #(
   parameter int BIT_WIDTH = 16,
   parameter int NUM_SEG   = 16,
   parameter int SEG_AW    = 4,
   parameter int PIPE_LAT  = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_cfg_start,
   input  logic                   i_cfg_valid,
   input  logic [2*BIT_WIDTH-1:0] i_cfg_data,
   output logic                   o_cfg_ready,
   output logic                   o_coef_we,
   output logic [SEG_AW-1:0]      o_coef_addr,
   output logic [2*BIT_WIDTH-1:0] o_coef_data,
   input  logic                   i_in_valid,
   output logic                   o_in_ready,
   output logic                   o_dp_en,
   output logic                   o_out_valid,
   output logic [15:0]            o_out_count,
   output logic                   o_coef_loaded,
   output logic                   o_busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_SETTLE = 3'd2,
      S_READY  = 3'd3,
      S_DRAIN  = 3'd4
   } state_t;

   localparam logic [SEG_AW-1:0]      SEG_ZERO  = {SEG_AW{1'b0}};
   localparam logic [SEG_AW-1:0]      SEG_ONE   = SEG_AW'(1);
   localparam logic [SEG_AW-1:0]      SEG_LAST  = SEG_AW'(NUM_SEG - 1);
   localparam logic [2*BIT_WIDTH-1:0] DATA_ZERO = {(2*BIT_WIDTH){1'b0}};
   localparam logic [PIPE_LAT-1:0]    PIPE_ZERO = {PIPE_LAT{1'b0}};

   state_t                 state_q, state_d;
   logic [SEG_AW-1:0]      seg_q, seg_d;
   logic [PIPE_LAT-1:0]    pipe_q, pipe_d;
   logic                   coef_we_q, coef_we_d;
   logic [SEG_AW-1:0]      coef_addr_q, coef_addr_d;
   logic [2*BIT_WIDTH-1:0] coef_data_q, coef_data_d;
   logic [15:0]            count_q, count_d;
   logic                   loaded_q, loaded_d;
   logic                   busy_q, busy_d;
   logic                   cfg_accept_s;
   logic                   dp_en_s;

   // Handshake decodes depend only on the registered state.
   assign cfg_accept_s = i_cfg_valid & (state_q == S_LOAD);
   assign dp_en_s      = i_in_valid & (state_q == S_READY);

   // Next-state, coefficient write, result pipe and counter logic.
   always_comb begin
      state_d     = state_q;
      seg_d       = seg_q;
      coef_we_d   = 1'b0;
      coef_addr_d = coef_addr_q;
      coef_data_d = coef_data_q;
      loaded_d    = loaded_q;
      pipe_d      = pipe_q;

      pipe_d[0] = dp_en_s;
      for (int i = 1; i < PIPE_LAT; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end

      if (pipe_q[PIPE_LAT-1]) begin
         count_d = count_q + 16'd1;
      end else begin
         count_d = count_q;
      end

      case (state_q)
         S_IDLE: begin
            if (i_cfg_start) begin
               state_d = S_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            if (cfg_accept_s) begin
               coef_we_d   = 1'b1;
               coef_addr_d = seg_q;
               coef_data_d = i_cfg_data;
               seg_d       = seg_q + SEG_ONE;
               if (seg_q == SEG_LAST) begin
                  state_d = S_SETTLE;
               end else begin
                  state_d = S_LOAD;
               end
            end else begin
               state_d = S_LOAD;
            end
         end
         S_SETTLE: begin
            state_d  = S_READY;
            loaded_d = 1'b1;
         end
         S_READY: begin
            if (i_cfg_start) begin
               state_d = S_DRAIN;
            end else begin
               state_d = S_READY;
            end
         end
         S_DRAIN: begin
            // Results still in flight must emerge before the table is rewritten.
            if (pipe_q == PIPE_ZERO) begin
               state_d = S_LOAD;
            end else begin
               state_d = S_DRAIN;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if ((state_d == S_LOAD) && (state_q != S_LOAD)) begin
         seg_d    = SEG_ZERO;
         loaded_d = 1'b0;
         count_d  = 16'd0;
      end else begin
         seg_d    = seg_d;
      end

      busy_d = (state_d != S_READY);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         seg_q       <= SEG_ZERO;
         pipe_q      <= PIPE_ZERO;
         coef_we_q   <= 1'b0;
         coef_addr_q <= SEG_ZERO;
         coef_data_q <= DATA_ZERO;
         count_q     <= 16'd0;
         loaded_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         seg_q       <= seg_d;
         pipe_q      <= pipe_d;
         coef_we_q   <= coef_we_d;
         coef_addr_q <= coef_addr_d;
         coef_data_q <= coef_data_d;
         count_q     <= count_d;
         loaded_q    <= loaded_d;
         busy_q      <= busy_d;
      end
   end

   assign o_cfg_ready   = (state_q == S_LOAD);
   assign o_in_ready    = (state_q == S_READY);
   assign o_dp_en       = dp_en_s;
   assign o_out_valid   = pipe_q[PIPE_LAT-1];
   assign o_coef_we     = coef_we_q;
   assign o_coef_addr   = coef_addr_q;
   assign o_coef_data   = coef_data_q;
   assign o_out_count   = count_q;
   assign o_coef_loaded = loaded_q;
   assign o_busy        = busy_q;

endmodule

// File: tb/tb_nfu3_seq_ctrl.sv
// Directed scoreboard bench for nfu3_seq_ctrl: coefficient writes and result
// valids are queued when driven and checked when the DUT produces them.
`timescale 1ns/1ps
module tb_nfu3_seq_ctrl;

   localparam int BW  = 16;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_cfg_start;
   logic          i_cfg_valid;
   logic [2*BW-1:0] i_cfg_data;
   logic          o_cfg_ready;
   logic          o_coef_we;
   logic [3:0]    o_coef_addr;
   logic [2*BW-1:0] o_coef_data;
   logic          i_in_valid;
   logic          o_in_ready;
   logic          o_dp_en;
   logic          o_out_valid;
   logic [15:0]   o_out_count;
   logic          o_coef_loaded;
   logic          o_busy;

   typedef struct {
      int          cyc;
      logic [3:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t wq[$];
   int  oq[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc    = 0;

   nfu3_seq_ctrl #(.BIT_WIDTH(16), .NUM_SEG(16), .SEG_AW(4), .PIPE_LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .i_cfg_start(i_cfg_start), .i_cfg_valid(i_cfg_valid), .i_cfg_data(i_cfg_data),
      .o_cfg_ready(o_cfg_ready), .o_coef_we(o_coef_we), .o_coef_addr(o_coef_addr),
      .o_coef_data(o_coef_data), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
      .o_dp_en(o_dp_en), .o_out_valid(o_out_valid), .o_out_count(o_out_count),
      .o_coef_loaded(o_coef_loaded), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Advance one cycle; at the falling edge compare DUT outputs against the queues.
   task automatic tick();
      wr_t e;
      int  oc;
      @(negedge clk);
      if (o_coef_we === 1'b1) begin
         if (wq.size() == 0) begin
            chk("coef_we_unexpected", {31'd0, o_coef_we}, 32'd0);
         end else begin
            e = wq.pop_front();
            chk("coef_we_cycle", 32'(cyc), 32'(e.cyc));
            chk("coef_addr", {28'd0, o_coef_addr}, {28'd0, e.addr});
            chk("coef_data", o_coef_data, e.data);
         end
      end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
         chk("coef_we_missing", {31'd0, o_coef_we}, 32'd1);
         void'(wq.pop_front());
      end
      if (o_out_valid === 1'b1) begin
         if (oq.size() == 0) begin
            chk("out_valid_unexpected", {31'd0, o_out_valid}, 32'd0);
         end else begin
            oc = oq.pop_front();
            chk("out_valid_cycle", 32'(cyc), 32'(oc));
         end
      end else if (oq.size() > 0 && oq[0] <= cyc) begin
         chk("out_valid_missing", {31'd0, o_out_valid}, 32'd1);
         void'(oq.pop_front());
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_load(input bit gaps, input int n, input bit ramp);
      logic [31:0] d;
      for (int k = 0; k < n; k++) begin
         d = ramp ? {16'(k + 1), 16'h0000} : $urandom;
         i_cfg_valid = 1'b1;
         i_cfg_data  = d;
         i_cfg_start = 1'b0;
         #1;
         chk("load_cfg_ready", {31'd0, o_cfg_ready}, 32'd1);
         chk("load_in_ready", {31'd0, o_in_ready}, 32'd0);
         chk("load_loaded", {31'd0, o_coef_loaded}, 32'd0);
         chk("load_count_clr", {16'd0, o_out_count}, 32'd0);
         wq.push_back('{cyc + 1, 4'(k), d});
         tick();
         if (gaps && k < n - 1) begin
            i_cfg_valid = 1'b0;
            i_cfg_data  = $urandom;
            i_cfg_start = 1'b1;
            #1;
            chk("gap_cfg_ready", {31'd0, o_cfg_ready}, 32'd1);
            chk("gap_in_ready", {31'd0, o_in_ready}, 32'd0);
            tick();
         end
      end
      i_cfg_valid = 1'b0;
      i_cfg_start = 1'b0;
   endtask

   task automatic finish_load();
      #1;
      chk("settle_cfg_ready", {31'd0, o_cfg_ready}, 32'd0);
      chk("settle_in_ready", {31'd0, o_in_ready}, 32'd0);
      chk("settle_loaded", {31'd0, o_coef_loaded}, 32'd0);
      tick();
      #1;
      chk("ready_loaded", {31'd0, o_coef_loaded}, 32'd1);
      chk("ready_in_ready", {31'd0, o_in_ready}, 32'd1);
      chk("ready_busy", {31'd0, o_busy}, 32'd0);
      chk("ready_cfg_ready", {31'd0, o_cfg_ready}, 32'd0);
   endtask

   task automatic op(input bit v, input bit acc);
      i_in_valid = v;
      #1;
      chk("dp_en", {31'd0, o_dp_en}, {31'd0, acc});
      if (acc) oq.push_back(cyc + LAT);
      tick();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_cfg_ready"}, {31'd0, o_cfg_ready}, 32'd0);
      chk({tag, "_in_ready"}, {31'd0, o_in_ready}, 32'd0);
      chk({tag, "_dp_en"}, {31'd0, o_dp_en}, 32'd0);
      chk({tag, "_coef_we"}, {31'd0, o_coef_we}, 32'd0);
      chk({tag, "_coef_addr"}, {28'd0, o_coef_addr}, 32'd0);
      chk({tag, "_coef_data"}, o_coef_data, 32'd0);
      chk({tag, "_out_valid"}, {31'd0, o_out_valid}, 32'd0);
      chk({tag, "_out_count"}, {16'd0, o_out_count}, 32'd0);
      chk({tag, "_loaded"}, {31'd0, o_coef_loaded}, 32'd0);
      chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
   endtask

   initial begin
      rst         = 1'b1;
      i_cfg_start = 1'b0;
      i_cfg_valid = 1'b1;
      i_cfg_data  = 32'hDEAD_BEEF;
      i_in_valid  = 1'b1;
      @(posedge clk);
      #1;
      #1;
      chk_all_zero("reset");
      tick();
      rst = 1'b0;
      #1;
      chk_all_zero("reset_hold");
      tick();
      #1;
      chk("idle_busy", {31'd0, o_busy}, 32'd1);
      chk("idle_cfg_ready", {31'd0, o_cfg_ready}, 32'd0);
      chk("idle_dp_en", {31'd0, o_dp_en}, 32'd0);
      tick();
      i_cfg_valid = 1'b0;
      i_in_valid  = 1'b0;

      // Ramp load with continuous valid.
      i_cfg_start = 1'b1;
      #1;
      chk("start_cfg_ready", {31'd0, o_cfg_ready}, 32'd0);
      tick();
      do_load(1'b0, 16, 1'b1);
      finish_load();

      // Five back-to-back operands.
      for (int i = 0; i < 5; i++) op(1'b1, 1'b1);
      for (int i = 0; i < 3; i++) op(1'b0, 1'b0);
      #1;
      chk("count_five", {16'd0, o_out_count}, 32'd5);

      // Reload request together with an accepted operand.
      i_cfg_start = 1'b1;
      i_in_valid  = 1'b1;
      #1;
      chk("drain_dp_en_t", {31'd0, o_dp_en}, 32'd1);
      oq.push_back(cyc + LAT);
      tick();
      i_cfg_start = 1'b0;
      #1;
      chk("drain_in_ready_t1", {31'd0, o_in_ready}, 32'd0);
      chk("drain_dp_en_t1", {31'd0, o_dp_en}, 32'd0);
      chk("drain_busy_t1", {31'd0, o_busy}, 32'd1);
      tick();
      #1;
      chk("drain_cfg_ready_t2", {31'd0, o_cfg_ready}, 32'd0);
      tick();
      #1;
      chk("drain_cfg_ready_t3", {31'd0, o_cfg_ready}, 32'd0);
      chk("drain_count_t3", {16'd0, o_out_count}, 32'd6);
      tick();
      i_in_valid = 1'b0;
      do_load(1'b1, 16, 1'b0);
      finish_load();

      // Reload from an empty pipe, then reset after the 8th accept.
      i_cfg_start = 1'b1;
      tick();
      i_cfg_start = 1'b0;
      #1;
      chk("empty_drain_cfg_ready", {31'd0, o_cfg_ready}, 32'd0);
      chk("empty_drain_in_ready", {31'd0, o_in_ready}, 32'd0);
      tick();
      do_load(1'b0, 8, 1'b0);
      rst         = 1'b1;
      i_cfg_valid = 1'b1;
      i_in_valid  = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk_all_zero("midload_rst");
      tick();
      i_cfg_valid = 1'b0;
      i_in_valid  = 1'b0;
      #1;
      chk("post_rst_busy", {31'd0, o_busy}, 32'd1);
      chk("post_rst_cfg_ready", {31'd0, o_cfg_ready}, 32'd0);
      i_cfg_start = 1'b1;
      tick();
      do_load(1'b0, 16, 1'b0);
      finish_load();

      // Counter wrap.
      for (int i = 0; i < 65535; i++) op(1'b1, 1'b1);
      for (int i = 0; i < 3; i++) op(1'b0, 1'b0);
      #1;
      chk("count_ffff", {16'd0, o_out_count}, 32'h0000_FFFF);
      op(1'b1, 1'b1);
      for (int i = 0; i < 3; i++) op(1'b0, 1'b0);
      #1;
      chk("count_wrap", {16'd0, o_out_count}, 32'd0);

      chk("write_queue_empty", 32'(wq.size()), 32'd0);
      chk("result_queue_empty", 32'(oq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
